// File: rtl/nonogram_pkg.sv
// -----------------------------------------------------------------------------
// nonogram_pkg
//
// Shared sizing and types for the nonogram output path.
//   MAX_ROWS / MAX_COLS : largest board the solver produces (each <= 15)
//   DIM_W               : width of the row/column count fields
//   CELLS / CNT_W       : board bit count and the width of a cell counter
//   HDR_*               : layout of the frame header byte {rows, cols}
//   ser_state_t         : solution_serializer FSM states
//   clamp_dim           : saturate a requested dimension to the board limit
// -----------------------------------------------------------------------------
package nonogram_pkg;

  localparam int MAX_ROWS = 11;
  localparam int MAX_COLS = 11;
  localparam int DIM_W    = 4;

  localparam int CELLS = MAX_ROWS * MAX_COLS;
  // Wide enough to hold the cell count itself, not just the last index.
  localparam int CNT_W = $clog2(CELLS + 1);

  // Header byte: row count in the upper nibble, column count in the lower.
  localparam int HDR_NIB_W = 4;
  localparam int HDR_M_LSB = 4;
  localparam int HDR_N_LSB = 0;

  typedef enum logic [2:0] {
    SER_IDLE   = 3'd0,
    SER_HEADER = 3'd1,
    SER_WAIT   = 3'd2,
    SER_PACK   = 3'd3,
    SER_DONE   = 3'd4
  } ser_state_t;

  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] v,
                                                 input logic [DIM_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/solution_serializer.sv
// -----------------------------------------------------------------------------
// solution_serializer
//
// Sits between the solver and uart_tx. When the solver reports a finished
// board, the board and its dimensions are latched and streamed out as:
//   byte 0     : header {rows[3:0], cols[3:0]}
//   byte 1..k  : cells in row-major order, packed LSB-first, 8 per byte;
//                unused high bits of the final byte are 0
// After the final byte is acknowledged, `done` pulses once.
//
// Ports
//   clk           in   system clock (50 MHz domain)
//   rst           in   asynchronous, active-high reset
//   valid_in      in   1-cycle pulse: solution/m/n valid (accepted in IDLE only)
//   solution      in   board bits, bit r*MAX_COLS+c = cell (r,c), 1 = filled
//   m, n          in   active rows / columns (saturated to MAX_ROWS / MAX_COLS)
//   transmit_done in   1-cycle pulse from uart_tx: previous byte shifted out
//   send          out  1-cycle pulse: byte_out valid, start transmission
//   byte_out      out  byte to transmit, stable from send until the next send
//   done          out  1-cycle pulse after the final byte's transmit_done
//   busy          out  high from the cycle after accepted valid_in through done
//
// Handshake with uart_tx: `send` is a one-cycle request carrying byte_out;
// exactly one `transmit_done` is expected in reply, and no new `send` is
// issued until it arrives. transmit_done seen in any state other than WAIT
// is treated as spurious and ignored. valid_in is only honoured in IDLE.
//
// The FSM state is held in the typed variable `state` (ser_state_t) so that
// checkers can bind to it directly.
// -----------------------------------------------------------------------------
module solution_serializer
  import nonogram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [CELLS-1:0] solution,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] n,
  input  logic             transmit_done,
  output logic             send,
  output logic [7:0]       byte_out,
  output logic             done,
  output logic             busy
);

  ser_state_t       state;

  // Frame latches, captured once in IDLE and stable for the whole frame.
  logic [CELLS-1:0] board;
  logic [DIM_W-1:0] m_l;
  logic [DIM_W-1:0] n_l;
  logic [CNT_W-1:0] total;

  // Walk position through the active region.
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic [CNT_W-1:0] cell_idx;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Combinational helpers.
  logic [DIM_W-1:0] m_clip;
  logic [DIM_W-1:0] n_clip;
  logic [CNT_W-1:0] cell_pos;
  logic             cell_bit;
  logic [7:0]       packed_byte;
  logic             last_cell;
  logic             cells_left;
  logic             byte_full;
  logic             col_wrap;
  logic [7:0]       hdr_byte;

  always_comb begin
    m_clip = clamp_dim(m, DIM_W'(MAX_ROWS));
    n_clip = clamp_dim(n, DIM_W'(MAX_COLS));

    // The latched board always uses the full MAX_COLS stride, regardless of
    // how many columns are active.
    cell_pos    = CNT_W'(row) * CNT_W'(MAX_COLS) + CNT_W'(col);
    cell_bit    = board[cell_pos];
    packed_byte = shift | (8'(cell_bit) << bit_idx);

    last_cell  = (cell_idx == (total - CNT_W'(1)));
    cells_left = (cell_idx < total);
    byte_full  = (bit_idx == 3'd7);
    col_wrap   = (col == (n_l - DIM_W'(1)));

    hdr_byte = '0;
    hdr_byte[HDR_M_LSB +: HDR_NIB_W] = m_l[HDR_NIB_W-1:0];
    hdr_byte[HDR_N_LSB +: HDR_NIB_W] = n_l[HDR_NIB_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SER_IDLE;
      board    <= '0;
      m_l      <= '0;
      n_l      <= '0;
      total    <= '0;
      row      <= '0;
      col      <= '0;
      cell_idx <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      send     <= 1'b0;
      byte_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises them for one cycle.
      send <= 1'b0;
      done <= 1'b0;

      case (state)
        SER_IDLE: begin
          if (valid_in) begin
            board    <= solution;
            m_l      <= m_clip;
            n_l      <= n_clip;
            // Registered once here so the PACK path only compares.
            total    <= CNT_W'(m_clip) * CNT_W'(n_clip);
            row      <= '0;
            col      <= '0;
            cell_idx <= '0;
            bit_idx  <= '0;
            busy     <= 1'b1;
            state    <= SER_HEADER;
          end
        end

        SER_HEADER: begin
          byte_out <= hdr_byte;
          send     <= 1'b1;
          state    <= SER_WAIT;
        end

        SER_WAIT: begin
          if (transmit_done) begin
            if (cells_left) begin
              shift <= '0;
              state <= SER_PACK;
            end else begin
              done  <= 1'b1;
              state <= SER_DONE;
            end
          end
        end

        SER_PACK: begin
          shift    <= packed_byte;
          cell_idx <= cell_idx + CNT_W'(1);
          // bit_idx wraps naturally from 7 to 0 for the next byte.
          bit_idx  <= bit_idx + 3'd1;
          if (col_wrap) begin
            col <= '0;
            row <= row + DIM_W'(1);
          end else begin
            col <= col + DIM_W'(1);
          end
          if (byte_full || last_cell) begin
            byte_out <= packed_byte;
            send     <= 1'b1;
            state    <= SER_WAIT;
          end
        end

        SER_DONE: begin
          busy  <= 1'b0;
          state <= SER_IDLE;
        end

        default: begin
          state <= SER_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solution_serializer.sv
// -----------------------------------------------------------------------------
// tb_solution_serializer
//
// Drives solved boards into solution_serializer, plays the uart_tx side
// (answers every send with transmit_done after a programmable delay), and
// checks the captured byte stream against a frame model built directly from
// the board, its clipped dimensions and the packing rules.
// -----------------------------------------------------------------------------
module tb_solution_serializer;
  import nonogram_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [CELLS-1:0] solution;
  logic [DIM_W-1:0] m;
  logic [DIM_W-1:0] n;
  logic             transmit_done;
  logic             send;
  logic [7:0]       byte_out;
  logic             done;
  logic             busy;

  always #5 clk = ~clk;

  solution_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .solution      (solution),
    .m             (m),
    .n             (n),
    .transmit_done (transmit_done),
    .send          (send),
    .byte_out      (byte_out),
    .done          (done),
    .busy          (busy)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int comps = 0;
  int fails = 0;

  // uart_tx responder / monitor state
  int cyc = 0;
  int resp_delay = 1;
  int cd = 0;
  int outstanding = 0;
  int overlap_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_td_cyc = 0;
  int td_count = 0;
  int since_td = 0;
  int spur_at = 0;
  int spur_fired = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    comps++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  // Frame model: header of clipped dims, then cells in row-major order,
  // eight per byte, first cell in bit 0.
  task automatic build_exp(input logic [CELLS-1:0] b, input int mm, input int nn);
    int mr;
    int nr;
    int cells;
    logic [7:0] v;
    logic [3:0] mh;
    logic [3:0] nh;
    mr = (mm > MAX_ROWS) ? MAX_ROWS : mm;
    nr = (nn > MAX_COLS) ? MAX_COLS : nn;
    mh = 4'(mr);
    nh = 4'(nr);
    exp_q.delete();
    exp_q.push_back({mh, nh});
    cells = mr * nr;
    for (int k = 0; k < cells; k += 8) begin
      v = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (k + j < cells)
          v[j] = b[((k + j) / nr) * MAX_COLS + ((k + j) % nr)];
      end
      exp_q.push_back(v);
    end
  endtask

  function automatic logic [CELLS-1:0] make_board(input int pat);
    logic [CELLS-1:0] b;
    b = '0;
    for (int r = 0; r < MAX_ROWS; r++)
      for (int c = 0; c < MAX_COLS; c++)
        case (pat)
          1:       b[r*MAX_COLS+c] = 1'b1;
          2:       b[r*MAX_COLS+c] = 1'((r + c) % 2);
          3:       b[r*MAX_COLS+c] = (r == c) && (r < 3);
          4:       b[r*MAX_COLS+c] = 1'($urandom_range(0, 1));
          default: b[r*MAX_COLS+c] = 1'b0;
        endcase
    return b;
  endfunction

  // ---------------------------------------------------------------- responder
  initial begin
    transmit_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      transmit_done = 1'b0;
      if (rst) begin
        cd = 0;
        outstanding = 0;
        since_td = 0;
      end else begin
        if (send) begin
          got_q.push_back(byte_out);
          if (outstanding != 0) overlap_cnt++;
          outstanding = 1;
          cd = resp_delay;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            transmit_done = 1'b1;
            outstanding = 0;
            last_td_cyc = cyc;
            td_count++;
            since_td = 0;
          end
        end else begin
          since_td++;
          // Spurious pulse two cycles after a real one lands inside PACK.
          if (spur_at > 0 && td_count == spur_at && since_td == 2) begin
            transmit_done = 1'b1;
            spur_at = 0;
            spur_fired = 1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic start_frame(input logic [CELLS-1:0] b, input int mm, input int nn);
    @(negedge clk);
    got_q.delete();
    done_cnt = 0;
    solution = b;
    m = DIM_W'(mm);
    n = DIM_W'(nn);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check("busy_after_valid", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (3) @(negedge clk);
    check({nm, "_done_once"}, 32'(done_cnt), 32'd1);
    check({nm, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string nm);
    check({nm, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({nm, "_overlap"}, 32'(overlap_cnt), 32'd0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int         mm;
    int         nn;
    int         pat;
    logic [7:0] hdr;
    int         nbytes;
    logic [7:0] last;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CELLS-1:0] ba;
    logic [CELLS-1:0] bb;
    int k;
    int nsent;

    tbl[0] = '{11, 11, 1, 8'hBB, 17, 8'h01};
    tbl[1] = '{ 0,  5, 1, 8'h05,  1, 8'h05};
    tbl[2] = '{14, 12, 1, 8'hBB, 17, 8'h01};
    tbl[3] = '{ 1,  1, 1, 8'h11,  2, 8'h01};
    tbl[4] = '{ 2,  4, 2, 8'h24,  2, 8'h5A};
    tbl[5] = '{ 4,  2, 0, 8'h42,  2, 8'h00};
    tbl[6] = '{ 5,  0, 1, 8'h50,  1, 8'h50};
    tbl[7] = '{15, 15, 0, 8'hBB, 17, 8'h00};
    tbl[8] = '{ 8,  1, 1, 8'h81,  2, 8'hFF};
    tbl[9] = '{ 3,  3, 1, 8'h33,  3, 8'h01};

    rst = 1'b1;
    valid_in = 1'b0;
    solution = '0;
    m = '0;
    n = '0;
    repeat (3) @(negedge clk);
    check("rst_send", 32'(send), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 11x11 all ones, slow uart
    resp_delay = 100;
    start_frame(make_board(1), 11, 11);
    wait_done("full11", 5000);
    check("full11_len", 32'(got_q.size()), 32'd17);
    if (got_q.size() == 17) begin
      check("full11_hdr", 32'(got_q[0]), 32'hBB);
      for (int i = 1; i <= 15; i++)
        check($sformatf("full11_b%0d", i), 32'(got_q[i]), 32'hFF);
      check("full11_last", 32'(got_q[16]), 32'h01);
    end
    check("full11_overlap", 32'(overlap_cnt), 32'd0);

    // 3x3 diagonal
    resp_delay = 4;
    start_frame(make_board(3), 3, 3);
    wait_done("diag3", 2000);
    check("diag3_len", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("diag3_hdr", 32'(got_q[0]), 32'h33);
      check("diag3_b1", 32'(got_q[1]), 32'h11);
      check("diag3_b2", 32'(got_q[2]), 32'h01);
    end

    // header only: done exactly one cycle after its transmit_done
    resp_delay = 5;
    start_frame(make_board(1), 0, 5);
    wait_done("hdr_only", 2000);
    check("hdr_only_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) check("hdr_only_hdr", 32'(got_q[0]), 32'h05);
    check("hdr_only_done_lat", 32'(done_cyc - last_td_cyc), 32'd1);

    // table vectors
    for (int t = 0; t < 10; t++) begin
      resp_delay = $urandom_range(1, 6);
      ba = make_board(tbl[t].pat);
      build_exp(ba, tbl[t].mm, tbl[t].nn);
      start_frame(ba, tbl[t].mm, tbl[t].nn);
      wait_done($sformatf("tbl%0d", t), 3000);
      check($sformatf("tbl%0d_hdr", t), 32'(got_q.size() > 0 ? got_q[0] : 8'hxx), 32'(tbl[t].hdr));
      check($sformatf("tbl%0d_nbytes", t), 32'(got_q.size()), 32'(tbl[t].nbytes));
      check($sformatf("tbl%0d_last", t),
            32'(got_q.size() > 0 ? got_q[got_q.size()-1] : 8'hxx), 32'(tbl[t].last));
      check_frame($sformatf("tbl%0d", t));
    end

    // second valid_in mid-frame plus a spurious transmit_done during PACK
    resp_delay = 30;
    ba = make_board(4);
    bb = ~ba;
    build_exp(ba, 11, 11);
    spur_fired = 0;
    spur_at = td_count + 3;
    start_frame(ba, 11, 11);
    repeat (60) @(negedge clk);
    solution = bb;
    m = 4'd3;
    n = 4'd3;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_done("midframe", 5000);
    check_frame("midframe");
    check("midframe_spur_fired", 32'(spur_fired), 32'd1);

    // valid_in coincident with done is ignored
    resp_delay = 3;
    start_frame(make_board(1), 2, 2);
    k = 0;
    while (done !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("coinc_done_seen", 32'(done), 32'd1);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    nsent = got_q.size();
    repeat (20) @(negedge clk);
    check("coinc_busy", 32'(busy), 32'd0);
    check("coinc_no_send", 32'(got_q.size()), 32'(nsent));

    // async reset in the WAIT of byte 5
    resp_delay = 20;
    start_frame(make_board(1), 11, 11);
    k = 0;
    while (got_q.size() < 5 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("arst_reached_b5", 32'(got_q.size()), 32'd5);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_send", 32'(send), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_byte_out", 32'(byte_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_delay = 3;
    ba = make_board(3);
    build_exp(ba, 3, 3);
    start_frame(ba, 3, 3);
    wait_done("arst_restart", 2000);
    check_frame("arst_restart");

    // random boards and dimensions
    for (int t = 0; t < 15; t++) begin
      int mm;
      int nn;
      mm = $urandom_range(0, 15);
      nn = $urandom_range(0, 15);
      resp_delay = $urandom_range(1, 8);
      ba = make_board(4);
      build_exp(ba, mm, nn);
      start_frame(ba, mm, nn);
      wait_done($sformatf("rnd%0d", t), 4000);
      check_frame($sformatf("rnd%0d_%0dx%0d", t, mm, nn));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
